// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiters feeding the one-hot encoders.
// Pure declarations: no state, no timing.
package arb_pkg;

    localparam int ARB_N     = 4;
    localparam int ARB_PTR_W = $clog2(ARB_N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First requester at or after ptr (circularly), as a one-hot vector; zero if none.
    function automatic logic [ARB_N-1:0] rr_pick(
        input logic [ARB_N-1:0]     req,
        input logic [ARB_PTR_W-1:0] ptr
    );
        logic [ARB_N-1:0]     pick;
        logic [ARB_PTR_W-1:0] idx;
        pick = '0;
        for (int k = ARB_N - 1; k >= 0; k--) begin
            idx = ptr + ARB_PTR_W'(k);
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_mask_pick.sv
// Purpose: combinational round-robin pick; rotate by ptr, isolate lowest bit, rotate back.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows req/ptr directly. N must be a power of two.
module rr_mask_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick
);

    logic [N-1:0] rot;
    logic [N-1:0] rot_pick;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            rot[i] = req[ptr + PW'(i)];
        end
        rot_pick = rot & (-rot);
        for (int j = 0; j < N; j++) begin
            pick[j] = rot_pick[PW'(j) - ptr];
        end
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Purpose: round-robin arbiter producing a registered one-hot grant with a hold timeout.
// Latency: grant appears 1 clock after a request is seen in IDLE.
// Backpressure: owner keeps grant while its req stays high, up to MAX_HOLD cycles.
module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         gnt_vld,
    output logic         timeout
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);

    arb_state_t    state, state_nxt;
    logic [PW-1:0] ptr, ptr_nxt;
    logic [PW-1:0] owner, owner_nxt;
    logic [CW-1:0] hold_cnt, hold_cnt_nxt;
    logic [N-1:0]  gnt_nxt;
    logic          timeout_nxt;
    logic [N-1:0]  pick;
    logic [PW-1:0] pick_idx;

    rr_mask_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        owner_nxt    = owner;
        hold_cnt_nxt = hold_cnt;
        gnt_nxt      = gnt;
        timeout_nxt  = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (|req) begin
                    gnt_nxt      = pick;
                    owner_nxt    = pick_idx;
                    hold_cnt_nxt = CW'(1);
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                // Every release goes through IDLE so the encoder never sees overlap.
                if (!req[owner]) begin
                    gnt_nxt      = '0;
                    ptr_nxt      = owner + PW'(1);
                    hold_cnt_nxt = '0;
                    state_nxt    = IDLE;
                end else if (hold_cnt == HOLD_LIMIT) begin
                    gnt_nxt      = '0;
                    ptr_nxt      = owner + PW'(1);
                    hold_cnt_nxt = '0;
                    state_nxt    = IDLE;
                    timeout_nxt  = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + CW'(1);
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            hold_cnt <= hold_cnt_nxt;
            gnt      <= gnt_nxt;
            gnt_vld  <= |gnt_nxt;
            timeout  <= timeout_nxt;
        end
    end

endmodule
